multi_ultrasonic_scheduler: RTL

Parametrised successor to the single-sensor ultrasonic path: one block drives NUM_CH trigger/echo sensor pairs in round-robin time slots. It times each echo, converts the echo width to centimetres, and applies a per-channel exponential moving average. Filtered and raw distances go to drive logic and the display; per-channel valid and timeout flags report the status of each measurement.

---
 rtl/multi_ultrasonic_scheduler_if.sv | 33 +++
 rtl/multi_ultrasonic_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multi_ultrasonic_scheduler_if.sv
`default_nettype none
// ============================================================================
// multi_ultrasonic_scheduler_if
// Control, echo/trigger and result bundle for the multi-sensor scheduler.
// Revision: 1.0
// ============================================================================
interface multi_ultrasonic_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int DIST_W = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                       enable;
  logic [NUM_CH-1:0]          echo;
  logic [NUM_CH-1:0]          trig;
  logic [NUM_CH*DIST_W-1:0]   raw_dist;
  logic [NUM_CH*DIST_W-1:0]   avg_dist;
  logic [NUM_CH-1:0]          dist_valid;
  logic [NUM_CH-1:0]          timeout;
  logic                       overrun;
  logic [CH_W-1:0]            active_ch;

  modport master (
    output enable, echo,
    input  trig, raw_dist, avg_dist, dist_valid, timeout, overrun, active_ch
  );

  modport slave (
    input  enable, echo,
    output trig, raw_dist, avg_dist, dist_valid, timeout, overrun, active_ch
  );
endinterface
`default_nettype wire

// File: rtl/multi_ultrasonic_scheduler.sv
`default_nettype none
// ============================================================================
// multi_ultrasonic_scheduler
// Round-robin trigger/echo timing for NUM_CH sensors with per-channel EMA.
// Revision: 1.0
// ============================================================================
module multi_ultrasonic_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int DIST_W      = 8,
  parameter int SLOT_CYC    = 3_125_000,
  parameter int TRIG_CYC    = 500,
  parameter int TIMEOUT_CYC = 1_500_000,
  parameter int CYC_PER_CM  = 2900,
  parameter int EMA_SHIFT   = 2
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  multi_ultrasonic_scheduler_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW   = $clog2(SLOT_CYC + 1);
  localparam int TW   = $clog2(TRIG_CYC + 1);
  localparam int OW   = $clog2(TIMEOUT_CYC + 1);
  localparam int MW   = $clog2(CYC_PER_CM + 1);

  localparam logic [SW-1:0]     SLOT_LAST = SW'(SLOT_CYC - 1);
  localparam logic [TW-1:0]     TRIG_LAST = TW'(TRIG_CYC - 1);
  localparam logic [OW-1:0]     TO_LAST   = OW'(TIMEOUT_CYC - 1);
  localparam logic [MW-1:0]     CM_LAST   = MW'(CYC_PER_CM - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [DIST_W-1:0] DIST_MAX  = {DIST_W{1'b1}};
  localparam logic signed [DIST_W+1:0] DIST_MAX_S = {2'b00, {DIST_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_UPDATE, S_FAIL
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CH-1:0]        sync1_q, sync2_q, hist_q;
  logic [SW-1:0]            slot_q, slot_d;
  logic [TW-1:0]            trig_cnt_q, trig_cnt_d;
  logic [OW-1:0]            to_cnt_q, to_cnt_d;
  logic [MW-1:0]            sub_q, sub_d;
  logic [DIST_W-1:0]        cm_q, cm_d;
  logic [CH_W-1:0]          active_q;
  logic [NUM_CH*DIST_W-1:0] raw_q, avg_q;
  logic [NUM_CH-1:0]        primed_q, valid_q, tmo_q;
  logic                     overrun_q;

  logic                     tick;
  logic                     echo_rise, echo_fall;
  logic [DIST_W-1:0]        avg_cur, avg_new;
  logic signed [DIST_W+1:0] ema_diff, ema_sum;
  logic [CH_W-1:0]          active_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= bus.echo;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // Only the channel owning the slot can produce edges; others are ignored.
  assign echo_rise = sync2_q[active_q] & ~hist_q[active_q];
  assign echo_fall = ~sync2_q[active_q] & hist_q[active_q];

  assign tick   = bus.enable && (slot_q == SLOT_LAST);
  assign slot_d = (!bus.enable || tick) ? '0 : slot_q + SW'(1);

  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    to_cnt_d   = to_cnt_q;
    sub_d      = sub_q;
    cm_d       = cm_q;
    case (state_q)
      S_IDLE: begin
        trig_cnt_d = '0;
        if (tick) state_d = S_TRIG;
      end
      S_TRIG: begin
        if (trig_cnt_q == TRIG_LAST) begin
          state_d  = S_WAIT_RISE;
          to_cnt_d = '0;
        end else begin
          trig_cnt_d = trig_cnt_q + TW'(1);
        end
      end
      S_WAIT_RISE: begin
        to_cnt_d = to_cnt_q + OW'(1);
        if (echo_rise) begin
          state_d = S_MEASURE;
          sub_d   = '0;
          cm_d    = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_FAIL;
        end
      end
      S_MEASURE: begin
        to_cnt_d = to_cnt_q + OW'(1);
        if (sub_q == CM_LAST) begin
          sub_d = '0;
          if (cm_q != DIST_MAX) cm_d = cm_q + DIST_W'(1);
        end else begin
          sub_d = sub_q + MW'(1);
        end
        if (echo_fall)                state_d = S_UPDATE;
        else if (to_cnt_q == TO_LAST) state_d = S_FAIL;
      end
      S_UPDATE: state_d = S_IDLE;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      trig_cnt_q <= '0;
      to_cnt_q   <= '0;
      sub_q      <= '0;
      cm_q       <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      trig_cnt_q <= trig_cnt_d;
      to_cnt_q   <= to_cnt_d;
      sub_q      <= sub_d;
      cm_q       <= cm_d;
    end
  end

  // Filter runs two bits wider so the signed step and clamp cannot wrap.
  assign avg_cur  = avg_q[active_q*DIST_W +: DIST_W];
  assign ema_diff = $signed({2'b00, cm_q}) - $signed({2'b00, avg_cur});
  assign ema_sum  = $signed({2'b00, avg_cur}) + (ema_diff >>> EMA_SHIFT);

  always_comb begin
    avg_new = ema_sum[DIST_W-1:0];
    if (!primed_q[active_q])        avg_new = cm_q;
    else if (ema_sum < 0)           avg_new = '0;
    else if (ema_sum > DIST_MAX_S)  avg_new = DIST_MAX;
  end

  assign active_next = (active_q == CH_LAST) ? '0 : active_q + CH_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q  <= '0;
      raw_q     <= '0;
      avg_q     <= '0;
      primed_q  <= '0;
      valid_q   <= '0;
      tmo_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= '0;
      if (tick && state_q != S_IDLE) overrun_q <= 1'b1;
      if (state_q == S_UPDATE) begin
        raw_q[active_q*DIST_W +: DIST_W] <= cm_q;
        avg_q[active_q*DIST_W +: DIST_W] <= avg_new;
        primed_q[active_q] <= 1'b1;
        tmo_q[active_q]    <= 1'b0;
        valid_q[active_q]  <= 1'b1;
        active_q           <= active_next;
      end else if (state_q == S_FAIL) begin
        raw_q[active_q*DIST_W +: DIST_W] <= DIST_MAX;
        tmo_q[active_q]    <= 1'b1;
        active_q           <= active_next;
      end
    end
  end

  // Trigger decodes straight from state so reset drops it immediately.
  always_comb begin
    bus.trig = '0;
    if (state_q == S_TRIG) bus.trig[active_q] = 1'b1;
  end

  assign bus.raw_dist   = raw_q;
  assign bus.avg_dist   = avg_q;
  assign bus.dist_valid = valid_q;
  assign bus.timeout    = tmo_q;
  assign bus.overrun    = overrun_q;
  assign bus.active_ch  = active_q;
endmodule
`default_nettype wire
